// File: rtl/audio_rec_pkg.sv
// rtl/audio_rec_pkg.sv - shared types and sizing for the audio record/play controller
package audio_rec_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECORD    = 2'd1,
    ST_PLAY_WAIT = 2'd2,
    ST_PLAY      = 2'd3
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rp_addr_counter.sv
// rtl/rp_addr_counter.sv - sample RAM address counter shared by record and play paths
module rp_addr_counter
  import audio_rec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic              wrap,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || wrap) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == {ADDR_W{1'b1}});

endmodule

// File: rtl/rec_play_ctrl.sv
// rtl/rec_play_ctrl.sv - records codec samples into RAM and plays them back
module rec_play_ctrl
  import audio_rec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOOP   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              sample_end,
  input  logic              sample_req,
  input  logic [DATA_W-1:0] audio_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] play_sample,
  output logic              playback,
  output logic              recording,
  output logic [ADDR_W:0]   rec_len,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(depth_of(ADDR_W));
  localparam logic [ADDR_W:0] ONE_EXT  = (ADDR_W+1)'(1);
  localparam bit              LOOP_EN  = (LOOP != 0);

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic              terminal;
  logic [ADDR_W:0]   next_ext;
  logic              wr_now;
  logic              start_play;
  logic              req_now;
  logic              at_end;
  logic              loop_wrap;
  logic              read_next;
  logic              cnt_clr;
  logic              cnt_inc;

  assign next_ext   = {1'b0, count} + ONE_EXT;
  assign wr_now     = (state == ST_RECORD) && sample_end;
  assign start_play = (state == ST_IDLE) && play_start && !rec_start && (rec_len != '0);
  // A stop arriving with sample_req wins, so no read is launched that would be discarded.
  assign req_now    = (state == ST_PLAY) && sample_req && !stop;
  assign at_end     = (next_ext == rec_len);
  assign loop_wrap  = req_now && at_end && LOOP_EN;
  assign read_next  = req_now && (!at_end || LOOP_EN);

  assign cnt_clr = (state == ST_IDLE) && (rec_start || start_play);
  assign cnt_inc = wr_now || (read_next && !loop_wrap);

  rp_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_addr_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .wrap     (loop_wrap),
    .count    (count),
    .terminal (terminal)
  );

  always_comb begin
    mem_addr = count;
    if (start_play || loop_wrap) begin
      mem_addr = '0;
    end else if (read_next) begin
      mem_addr = next_ext[ADDR_W-1:0];
    end
  end

  assign mem_we    = wr_now;
  assign mem_re    = start_play || read_next;
  assign mem_wdata = audio_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rec_len     <= '0;
      play_sample <= '0;
      playback    <= 1'b0;
      recording   <= 1'b0;
      full        <= 1'b0;
    end else begin
      full <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rec_start) begin
            state     <= ST_RECORD;
            recording <= 1'b1;
            rec_len   <= '0;
          end else if (start_play) begin
            state    <= ST_PLAY_WAIT;
            playback <= 1'b1;
          end
        end
        ST_RECORD: begin
          if (sample_end) begin
            rec_len <= terminal ? FULL_LEN : next_ext;
          end
          if ((sample_end && terminal) || stop) begin
            state     <= ST_IDLE;
            recording <= 1'b0;
            full      <= sample_end && terminal;
          end
        end
        ST_PLAY_WAIT: begin
          if (stop) begin
            state       <= ST_IDLE;
            playback    <= 1'b0;
            play_sample <= '0;
          end else begin
            state       <= ST_PLAY;
            play_sample <= mem_rdata;
          end
        end
        ST_PLAY: begin
          if (stop || (sample_req && at_end && !LOOP_EN)) begin
            state       <= ST_IDLE;
            playback    <= 1'b0;
            play_sample <= '0;
          end else if (sample_req) begin
            state <= ST_PLAY_WAIT;
          end
        end
        default: begin
          state     <= ST_IDLE;
          playback  <= 1'b0;
          recording <= 1'b0;
        end
      endcase
    end
  end

endmodule
